reaction_ctrl: RTL and testbench
================================

// Module: reaction_ctrl
// PURPOSE
//  Game sequencer for the reaction timer. Sequences start, random hold-off, timing and result.
//  Drives the four 4-bit digit codes consumed by the seven-segment multiplexer.
//  Digit codes: 0-9 decimal, 10='H', 11='I', 15=dash. Timing is in 1 ms BCD units, max 9999.
// PARAMETERS
//  TICK_DIV     100000  clocks per 1 ms tick (100 MHz clock)
//  MIN_WAIT_MS  1000    fixed part of the hold-off, in ms
//  RAND_BITS    11      LFSR bits added to the hold-off (0..2^RAND_BITS-1 ms)
// PORTS
//  clock         in   1  system clock, all logic on posedge
//  reset         in   1  asynchronous, active-high; returns the block to IDLE
//  btn_start     in   1  raw start button, asynchronous to clock
//  btn_react     in   1  raw reaction button, asynchronous to clock
//  go_led        out  1  high only in GO
//  early         out  1  high only in EARLY
//  fourth_state  out  4  leftmost digit code (thousands)
//  third_state   out  4  hundreds digit code
//  second_state  out  4  tens digit code
//  first_state   out  4  rightmost digit code (units)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Inputs: each button passes a 2-FF synchroniser, then a rising-edge detect -> 1-cycle pulse.
//   Press-to-pulse latency is 3 clocks.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; reset seed 16'hACE1; advances every clock.
//  Tick: divider runs 0..TICK_DIV-1 and pulses tick at TICK_DIV-1.
//   The divider clears on entry to WAIT and to GO, so the first ms is always full.
//  FSM states, reset = IDLE:
//   IDLE  : shows H,I,-,- (10,11,15,15).
//           start_p -> WAIT; load wait_ms = MIN_WAIT_MS + lfsr[RAND_BITS-1:0].
//   WAIT  : shows ----. Each tick decrements wait_ms; tick at wait_ms==1 -> GO.
//           react_p -> EARLY (takes priority over a tick in the same cycle).
//   GO    : go_led=1; BCD counter cleared on entry; +1 per tick with digit carry.
//           Shows the live count. react_p -> DONE with the count frozen.
//           react_p and tick in the same cycle: no increment.
//           tick at 9999 -> DONE showing 9999 (saturate, no wrap).
//   DONE  : holds the final count on the digits. start_p -> WAIT with a new wait_ms.
//   EARLY : early=1, shows ----. start_p -> WAIT with a new wait_ms.
//  Ignored presses: start_p in WAIT or GO; react_p in IDLE, DONE or EARLY.
//   start_p and react_p in the same cycle: IDLE, DONE and EARLY take start; WAIT and GO take react.
//  Outputs are registered and update one clock after the state change.
//  Reset values: go_led=0, early=0, digits={10,11,15,15}, BCD=0, divider=0, LFSR=seed.
//   Reset mid-game aborts immediately to IDLE.
// CONFIGURATION
//  DEBOUNCE_EN defined:
//   A 16-bit stable counter sits per button between the synchroniser and the edge detect.
//   The level is accepted after 65536 consecutive equal samples; press latency becomes 65539 clocks.
//  DEBOUNCE_EN undefined:
//   Synchroniser plus edge detect only, latency 3 clocks.
//  All other behaviour is identical.
// TESTING  (TICK_DIV=4, MIN_WAIT_MS=2, RAND_BITS=2, DEBOUNCE_EN undefined)
//  Reset, no input -> go_led=0, early=0, digits 10,11,15,15; state held indefinitely.
//  start; lfsr[1:0]=1 at capture; no react -> GO entered after 3 ms (12 clocks);
//   go_led=1 and digits 0,0,0,0.
//  In GO, react after 37 ticks -> DONE, digits 0,0,3,7; go_led=0; display held for 1000 clocks.
//  In WAIT, react before go -> EARLY: early=1, digits all 15; a further start -> WAIT, early=0.
//  In GO, no react for 9999+ ticks -> DONE showing 9,9,9,9; no wrap to 0000.
//  Assert reset during GO -> IDLE asynchronously; next start begins cleanly with BCD=0.

Source files
------------

// File: rtl/reaction_ctrl.sv
// Reaction-timer game sequencer: button conditioning, random hold-off, ms timing, digit codes.
// Optional DEBOUNCE_EN inserts a 16-bit stable-level filter per button.
module reaction_ctrl #(
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned MIN_WAIT_MS = 1000,
   parameter int unsigned RAND_BITS   = 11
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_react,
   output logic       go_led,
   output logic       early,
   output logic [3:0] fourth_state,
   output logic [3:0] third_state,
   output logic [3:0] second_state,
   output logic [3:0] first_state
);

   localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned WAIT_W = $clog2(MIN_WAIT_MS + (1 << RAND_BITS)) + 1;

   typedef enum logic [2:0] {StIdle, StWait, StGo, StDone, StEarly} state_e;

   state_e             state_q, state_d;
   logic [1:0]         btn_meta_q, btn_sync_q, btn_prev_q, btn_pulse_q, btn_level;
   logic [15:0]        lfsr_q;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [WAIT_W-1:0]  wait_q, wait_d, wait_load;
   logic [3:0][3:0]    bcd_q, bcd_d, bcd_inc, digits_q, digits_d;
   logic               go_q, go_d, early_q, early_d;
   logic               tick, start_p, react_p, carry;

`ifdef DEBOUNCE_EN
   logic [1:0]       stable_q;
   logic [1:0][15:0] db_cnt_q;

   // Accept a new level only after 65536 consecutive samples that differ from the held one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stable_q <= '0;
         db_cnt_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (btn_sync_q[i] == stable_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == 16'hFFFF) begin
               stable_q[i] <= btn_sync_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
            end
         end
      end
   end

   assign btn_level = stable_q;
`else
   assign btn_level = btn_sync_q;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_meta_q  <= '0;
         btn_sync_q  <= '0;
         btn_prev_q  <= '0;
         btn_pulse_q <= '0;
         lfsr_q      <= 16'hACE1;
      end else begin
         btn_meta_q  <= {btn_react, btn_start};
         btn_sync_q  <= btn_meta_q;
         btn_prev_q  <= btn_level;
         btn_pulse_q <= btn_level & ~btn_prev_q;
         lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign start_p   = btn_pulse_q[0];
   assign react_p   = btn_pulse_q[1];
   assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
   assign wait_load = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr_q[RAND_BITS-1:0]);

   always_comb begin
      bcd_inc = bcd_q;
      carry   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (bcd_q[i] == 4'd9) begin
               bcd_inc[i] = 4'd0;
            end else begin
               bcd_inc[i] = bcd_q[i] + 4'd1;
               carry      = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      bcd_d   = bcd_q;
      unique case (state_q)
         StIdle, StDone, StEarly: begin
            if (start_p) begin
               state_d = StWait;
               wait_d  = wait_load;
            end
         end
         StWait: begin
            if (react_p) begin
               state_d = StEarly;
            end else if (tick) begin
               wait_d = wait_q - 1'b1;
               if (wait_q == WAIT_W'(1)) begin
                  state_d = StGo;
                  bcd_d   = '0;
               end
            end
         end
         StGo: begin
            if (react_p) begin
               state_d = StDone;
            end else if (tick) begin
               if (bcd_q == 16'h9999) state_d = StDone;
               else                   bcd_d   = bcd_inc;
            end
         end
         default: state_d = StIdle;
      endcase

      // Restart the divider when a timed phase begins so its first ms is full length.
      div_d = tick ? '0 : div_q + 1'b1;
      if (state_d != state_q && (state_d == StWait || state_d == StGo)) div_d = '0;
   end

   always_comb begin
      go_d     = 1'b0;
      early_d  = 1'b0;
      digits_d = {4'd15, 4'd15, 4'd15, 4'd15};
      unique case (state_q)
         StIdle:  digits_d = {4'd10, 4'd11, 4'd15, 4'd15};
         StGo: begin
            go_d     = 1'b1;
            digits_d = bcd_q;
         end
         StDone:  digits_d = bcd_q;
         StEarly: early_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         wait_q   <= '0;
         div_q    <= '0;
         bcd_q    <= '0;
         go_q     <= 1'b0;
         early_q  <= 1'b0;
         digits_q <= {4'd10, 4'd11, 4'd15, 4'd15};
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         div_q    <= div_d;
         bcd_q    <= bcd_d;
         go_q     <= go_d;
         early_q  <= early_d;
         digits_q <= digits_d;
      end
   end

   assign go_led       = go_q;
   assign early        = early_q;
   assign fourth_state = digits_q[3];
   assign third_state  = digits_q[2];
   assign second_state = digits_q[1];
   assign first_state  = digits_q[0];

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: a game-level timeline model predicts every distinct
// display snapshot; a negedge monitor pops and compares on each output change.
module tb_reaction_ctrl;

   localparam int unsigned TickDiv  = 4;
   localparam int unsigned MinWait  = 2;
   localparam int unsigned RandBits = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_react = 1'b0;
   logic       go_led, early;
   logic [3:0] fourth_state, third_state, second_state, first_state;

   reaction_ctrl #(
      .TICK_DIV   (TickDiv),
      .MIN_WAIT_MS(MinWait),
      .RAND_BITS  (RandBits)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_start   (btn_start),
      .btn_react   (btn_react),
      .go_led      (go_led),
      .early       (early),
      .fourth_state(fourth_state),
      .third_state (third_state),
      .second_state(second_state),
      .first_state (first_state)
   );

   always #5 clock = ~clock;

   // Clock edges seen since reset release; edge 1 is the first one after release.
   int n_edges;
   always @(posedge clock or posedge reset) begin
      if (reset) n_edges <= 0;
      else       n_edges <= n_edges + 1;
   end

   typedef logic [17:0] snap_t;  // {go_led, early, d4, d3, d2, d1}
   typedef enum int {MIdle, MWait, MGo, MDone, MEarly} mstate_e;

   snap_t   exp_q[$];
   snap_t   last_pushed, last_seen, idle_snap, dash_snap, early_snap;
   int      errors = 0;
   int      checks = 0;
   mstate_e ms;
   int      go_at, go_edge, cnt;

   function automatic snap_t mk(logic go, logic er, int d4, int d3, int d2, int d1);
      return {go, er, 4'(d4), 4'(d3), 4'(d2), 4'(d1)};
   endfunction

   function automatic snap_t count_snap(logic go, int v);
      return mk(go, 1'b0, v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10);
   endfunction

   function automatic string fmt(snap_t s);
      return $sformatf("go=%0b early=%0b digits=%0d,%0d,%0d,%0d",
                       s[17], s[16], s[15:12], s[11:8], s[7:4], s[3:0]);
   endfunction

   function automatic logic [15:0] lfsr_after(int steps);
      logic [15:0] s = 16'hACE1;
      for (int i = 0; i < steps; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      return s;
   endfunction

   task automatic push(snap_t s);
      if (s != last_pushed) begin
         exp_q.push_back(s);
         last_pushed = s;
      end
   endtask

   // Apply every button-independent event (go, ms ticks, saturation) at edges <= upto.
   task automatic advance(int upto);
      if (ms == MWait && go_at <= upto) begin
         ms = MGo;
         go_edge = go_at;
         cnt = 0;
         push(count_snap(1'b1, 0));
      end
      while (ms == MGo && go_edge + int'(TickDiv) * (cnt + 1) <= upto) begin
         if (cnt == 9999) begin
            ms = MDone;
            push(count_snap(1'b0, 9999));
         end else begin
            cnt++;
            push(count_snap(1'b1, cnt));
         end
      end
   endtask

   // A button pulse acting at edge r.
   task automatic pulse(bit is_react, int r);
      logic [15:0] l;
      advance(r - 1);
      if (ms == MIdle || ms == MDone || ms == MEarly) begin
         if (!is_react) begin
            l = lfsr_after(r - 1);
            ms = MWait;
            go_at = r + int'(TickDiv) * (int'(MinWait) + int'(l[RandBits-1:0]));
            push(dash_snap);
         end
      end else if (is_react) begin
         if (ms == MWait) begin
            ms = MEarly;
            push(early_snap);
         end else begin
            ms = MDone;
            push(count_snap(1'b0, cnt));
         end
      end else begin
         advance(r);
      end
   endtask

   // Press a button `gap` cycles from now; synchroniser plus edge detect put the pulse
   // at edge (press negedge count + 4).
   task automatic press(bit is_react, int gap);
      pulse(is_react, n_edges + gap + 4);
      repeat (gap) @(negedge clock);
      if (is_react) btn_react = 1'b1;
      else          btn_start = 1'b1;
      repeat (2) @(negedge clock);
      btn_react = 1'b0;
      btn_start = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic idle_wait(int cycles);
      advance(n_edges + cycles - 1);
      repeat (cycles) @(negedge clock);
   endtask

   task automatic check_outputs(string name, snap_t want);
      snap_t cur = {go_led, early, fourth_state, third_state, second_state, first_state};
      checks++;
      if (cur !== want) begin
         errors++;
         $display("FAIL %s: got %s, expected %s", name, fmt(cur), fmt(want));
      end
   endtask

   task automatic pulse_reset();
      advance(n_edges - 1);
      push(idle_snap);
      ms = MIdle;
      #1 reset = 1'b1;
      #2 check_outputs("async_reset", idle_snap);
      @(negedge clock);
      reset = 1'b0;
   endtask

   always @(negedge clock) begin
      snap_t cur, e;
      cur = {go_led, early, fourth_state, third_state, second_state, first_state};
      if (cur !== last_seen) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got %s, expected no change from %s",
                     fmt(cur), fmt(last_seen));
         end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
               errors++;
               $display("FAIL output_seq: got %s, expected %s", fmt(cur), fmt(e));
            end
         end
         last_seen = cur;
      end
   end

   initial begin
      int r;
      idle_snap   = mk(1'b0, 1'b0, 10, 11, 15, 15);
      dash_snap   = mk(1'b0, 1'b0, 15, 15, 15, 15);
      early_snap  = mk(1'b0, 1'b1, 15, 15, 15, 15);
      last_seen   = idle_snap;
      last_pushed = idle_snap;
      ms          = MIdle;

      repeat (2) @(negedge clock);
      check_outputs("reset_state", idle_snap);
      reset = 1'b0;
      idle_wait(60);
      check_outputs("idle_hold", idle_snap);

      // Full game: react during the 38th ms of GO, count 37, then hold the result.
      press(1'b0, 3);
      r = go_at + int'(TickDiv) * 37 + 1 + int'($urandom_range(0, 3));
      press(1'b1, r - 4 - n_edges);
      idle_wait(1000);
      check_outputs("done_hold", count_snap(1'b0, 37));

      // Early press, then restart from EARLY.
      press(1'b0, 2);
      press(1'b1, 2);
      idle_wait(20);
      check_outputs("early_state", early_snap);
      press(1'b0, 5);
      press(1'b1, int'($urandom_range(0, 60)));

      for (int i = 0; i < 24; i++) press(1'(($urandom >> 3) & 1), int'($urandom_range(0, 100)));

      // Reach GO, then reset asynchronously mid-count.
      press(1'b1, 3);
      press(1'b0, 3);
      idle_wait(go_at + 30 - n_edges);
      pulse_reset();
      idle_wait(10);
      press(1'b0, 4);
      press(1'b1, go_at + int'($urandom_range(10, 200)) - 4 - n_edges);

      // Saturation at 9999 ms.
      press(1'b0, 3);
      idle_wait(go_at + int'(TickDiv) * 10000 + 100 - n_edges);
      check_outputs("saturate", count_snap(1'b0, 9999));
      idle_wait(50);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d unseen, expected 0 (next %s)",
                  exp_q.size(), fmt(exp_q[0]));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
